// File: rtl/mem_port_arbiter.sv
// Arbitrates one multi-cycle req/ack memory port between instruction fetch (I) and data (D).
// Optional event counters are built only when ARB_STATS_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ireq_i,
  input  logic [31:0] iaddr_i,
  output logic [31:0] idata_o,
  output logic        iready_o,
  output logic        istall_o,
  input  logic        drd_i,
  input  logic        dwr_i,
  input  logic [31:0] daddr_i,
  input  logic [31:0] dwdata_i,
  output logic [31:0] drdata_o,
  output logic        dready_o,
  output logic        dstall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o,
  output logic [31:0] stat_igrant_o,
  output logic [31:0] stat_dgrant_o,
  output logic [31:0] stat_stall_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] WD_LIM     = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        gnt_d_q, gnt_d_d;       // 1: current grant belongs to D
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] idata_q, idata_d;
  logic [31:0] drdata_q, drdata_d;
  logic        iready_q, iready_d;
  logic        dready_q, dready_d;
  logic        err_q, err_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [7:0]  wd_cnt_q, wd_cnt_d;

  logic dreq;
  logic grant_i;
  logic grant_d;

  assign dreq = drd_i | dwr_i;

  // NOTE: every signal assigned in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    gnt_d_d      = gnt_d_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    idata_d      = idata_q;
    drdata_d     = drdata_q;
    iready_d     = 1'b0;
    dready_d     = 1'b0;
    err_d        = err_q;
    starve_cnt_d = starve_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // I wins outright once it has lost STARVE_MAX arbitrations in a row.
        if (ireq_i && (starve_cnt_q == STARVE_LIM)) grant_i = 1'b1;
        else if (dreq)                               grant_d = 1'b1;
        else if (ireq_i)                             grant_i = 1'b1;

        if (grant_i || grant_d) begin
          state_d     = S_BUSY;
          gnt_d_d     = grant_d;
          mem_req_d   = 1'b1;
          mem_we_d    = grant_d & dwr_i;
          mem_addr_d  = grant_d ? daddr_i : iaddr_i;
          mem_wdata_d = grant_d ? dwdata_i : 32'd0;
          wd_cnt_d    = 8'd0;
        end
      end

      S_BUSY: begin
        if (mem_ack_i) begin
          if (!gnt_d_q)       idata_d  = mem_rdata_i;
          else if (!mem_we_q) drdata_d = mem_rdata_i;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          iready_d  = ~gnt_d_q;
          dready_d  = gnt_d_q;
          state_d   = S_DONE;
        end else if (wd_cnt_q == WD_LIM) begin
          if (!gnt_d_q)       idata_d  = ERR_DATA;
          else if (!mem_we_q) drdata_d = ERR_DATA;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
          iready_d  = ~gnt_d_q;
          dready_d  = gnt_d_q;
          state_d   = S_DONE;
        end else begin
          wd_cnt_d = wd_cnt_q + 8'd1;
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (!ireq_i || grant_i)                        starve_cnt_d = 4'd0;
    else if (grant_d && (starve_cnt_q != STARVE_LIM)) starve_cnt_d = starve_cnt_q + 4'd1;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      gnt_d_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      idata_q      <= 32'd0;
      drdata_q     <= 32'd0;
      iready_q     <= 1'b0;
      dready_q     <= 1'b0;
      err_q        <= 1'b0;
      starve_cnt_q <= 4'd0;
      wd_cnt_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      gnt_d_q      <= gnt_d_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      idata_q      <= idata_d;
      drdata_q     <= drdata_d;
      iready_q     <= iready_d;
      dready_q     <= dready_d;
      err_q        <= err_d;
      starve_cnt_q <= starve_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  assign idata_o     = idata_q;
  assign drdata_o    = drdata_q;
  assign iready_o    = iready_q;
  assign dready_o    = dready_q;
  assign istall_o    = ireq_i & ~iready_q;
  assign dstall_o    = dreq & ~dready_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;

`ifdef ARB_STATS_EN
  logic [31:0] stat_igrant_q, stat_igrant_d;
  logic [31:0] stat_dgrant_q, stat_dgrant_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_igrant_d = stat_igrant_q + {31'd0, grant_i};
    stat_dgrant_d = stat_dgrant_q + {31'd0, grant_d};
    stat_stall_d  = stat_stall_q + {31'd0, istall_o | dstall_o};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_igrant_q <= 32'd0;
      stat_dgrant_q <= 32'd0;
      stat_stall_q  <= 32'd0;
    end else begin
      stat_igrant_q <= stat_igrant_d;
      stat_dgrant_q <= stat_dgrant_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_igrant_o = stat_igrant_q;
  assign stat_dgrant_o = stat_dgrant_q;
  assign stat_stall_o  = stat_stall_q;
`else
  assign stat_igrant_o = 32'd0;
  assign stat_dgrant_o = 32'd0;
  assign stat_stall_o  = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: bench-side memory responder, per-requester
// expected-data queues, directed timing checks for latency, priority, starvation, timeout and reset.
module tb_mem_port_arbiter;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned TIMEOUT    = 8;
  localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ireq_i = 1'b0;
  logic [31:0] iaddr_i = '0;
  logic [31:0] idata_o;
  logic        iready_o, istall_o;
  logic        drd_i = 1'b0, dwr_i = 1'b0;
  logic [31:0] daddr_i = '0, dwdata_i = '0;
  logic [31:0] drdata_o;
  logic        dready_o, dstall_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        err_o;
  logic [31:0] stat_igrant_o, stat_dgrant_o, stat_stall_o;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ireq_i(ireq_i), .iaddr_i(iaddr_i), .idata_o(idata_o), .iready_o(iready_o), .istall_o(istall_o),
    .drd_i(drd_i), .dwr_i(dwr_i), .daddr_i(daddr_i), .dwdata_i(dwdata_i),
    .drdata_o(drdata_o), .dready_o(dready_o), .dstall_o(dstall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o),
    .stat_igrant_o(stat_igrant_o), .stat_dgrant_o(stat_dgrant_o), .stat_stall_o(stat_stall_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  // Two copies: the responder's memory and the bench's expectation of it.
  logic [31:0] mem_model [0:63];
  logic [31:0] exp_mem   [0:63];
  logic [31:0] iq [$];
  logic [31:0] dq [$];
  logic [31:0] i_last_exp = '0;
  logic [31:0] d_last_exp = '0;
  bit          done_order [$];  // 0 = I completion, 1 = D completion
  int          cyc = 0;
  int          i_ready_cyc = 0, d_ready_cyc = 0;
  int unsigned n_igrant = 0, n_dgrant = 0, n_stall = 0;

  // Memory responder: acks in the ack_lat-th BUSY cycle; ack_lat == 0 never acks.
  int ack_lat      = 1;
  int busy_cyc     = 0;
  bit spurious_ack = 1'b0;

  always @(posedge clk_i) begin
    cyc++;
    #1;
    mem_ack_i = 1'b0;
    if (mem_req_o) begin
      busy_cyc++;
      if (ack_lat != 0 && busy_cyc == ack_lat) begin
        mem_ack_i = 1'b1;
        if (mem_we_o) mem_model[idx(mem_addr_o)] = mem_wdata_o;
        else          mem_rdata_i = mem_model[idx(mem_addr_o)];
      end
    end else begin
      busy_cyc = 0;
      if (spurious_ack) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h5A5A_5A5A;
      end
    end
  end

  logic [31:0] pop_v;
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if ((ireq_i && !iready_o) || ((drd_i || dwr_i) && !dready_o)) n_stall++;
      if (iready_o) begin
        i_ready_cyc = cyc;
        done_order.push_back(1'b0);
        if (iq.size() == 0) check("i_unexpected_ready", 32'd1, 32'd0);
        else begin
          pop_v = iq.pop_front();
          check("idata", idata_o, pop_v);
        end
      end
      if (dready_o) begin
        d_ready_cyc = cyc;
        done_order.push_back(1'b1);
        if (dq.size() == 0) check("d_unexpected_ready", 32'd1, 32'd0);
        else begin
          pop_v = dq.pop_front();
          check("drdata", drdata_o, pop_v);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready(input bit is_d, input int budget, input string tag);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk_i);
      if (is_d ? dready_o : iready_o) return;
    end
    check({tag, "_no_ready"}, 32'd0, 32'd1);
  endtask

  // Called at a posedge+1 point; returns at posedge+1 of the cycle after the ready pulse.
  task automatic i_read(input logic [31:0] addr, input bit to_err, input bit last);
    ireq_i  = 1'b1;
    iaddr_i = addr;
    i_last_exp = to_err ? ERR_DATA : exp_mem[idx(addr)];
    iq.push_back(i_last_exp);
    n_igrant++;
    wait_ready(1'b0, 100, "i_read");
    tick();
    if (last) ireq_i = 1'b0;
  endtask

  task automatic d_op(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input bit to_err, input bit last);
    drd_i    = ~we;
    dwr_i    = we;
    daddr_i  = addr;
    dwdata_i = wdata;
    if (we) begin
      exp_mem[idx(addr)] = wdata;
      dq.push_back(d_last_exp);
    end else begin
      d_last_exp = to_err ? ERR_DATA : exp_mem[idx(addr)];
      dq.push_back(d_last_exp);
    end
    n_dgrant++;
    wait_ready(1'b1, 100, "d_op");
    tick();
    if (last) begin
      drd_i = 1'b0;
      dwr_i = 1'b0;
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef ARB_STATS_EN
    check({tag, "_igrant"}, stat_igrant_o, n_igrant);
    check({tag, "_dgrant"}, stat_dgrant_o, n_dgrant);
    check({tag, "_stall"},  stat_stall_o,  n_stall);
`else
    check({tag, "_igrant"}, stat_igrant_o, 32'd0);
    check({tag, "_dgrant"}, stat_dgrant_o, 32'd0);
    check({tag, "_stall"},  stat_stall_o,  32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: got no finish expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int hi, n, nd;
    bit seen_i;
    for (int i = 0; i < 64; i++) begin
      mem_model[i] = 32'hC0DE_0000 | 32'(i);
      exp_mem[i]   = 32'hC0DE_0000 | 32'(i);
    end
    mem_model[16] = 32'h8C02_0004;
    exp_mem[16]   = 32'h8C02_0004;

    // Reset state
    repeat (3) tick();
    @(negedge clk_i);
    check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_iready",  {31'd0, iready_o},  32'd0);
    check("rst_idata",   idata_o,            32'd0);
    check("rst_err",     {31'd0, err_o},     32'd0);
    check("rst_stall_cnt", stat_stall_o,     32'd0);
    tick();
    rst_i = 1'b0;
    tick();

    // I read alone, exact cycle timing
    ack_lat = 1;
    ireq_i  = 1'b1;
    iaddr_i = 32'h40;
    i_last_exp = 32'h8C02_0004;
    iq.push_back(i_last_exp);
    n_igrant++;
    @(negedge clk_i);
    check("t1_c0_istall",  {31'd0, istall_o},  32'd1);
    check("t1_c0_mem_req", {31'd0, mem_req_o}, 32'd0);
    @(negedge clk_i);
    check("t1_c1_mem_req", {31'd0, mem_req_o}, 32'd1);
    check("t1_c1_addr",    mem_addr_o,         32'h40);
    check("t1_c1_we",      {31'd0, mem_we_o},  32'd0);
    check("t1_c1_istall",  {31'd0, istall_o},  32'd1);
    @(negedge clk_i);
    check("t1_c2_iready",  {31'd0, iready_o},  32'd1);
    check("t1_c2_idata",   idata_o,            32'h8C02_0004);
    check("t1_c2_istall",  {31'd0, istall_o},  32'd0);
    tick();
    ireq_i = 1'b0;
    @(negedge clk_i);
    check("t1_c3_iready",  {31'd0, iready_o},  32'd0);
    check("t1_c3_mem_req", {31'd0, mem_req_o}, 32'd0);
    tick();

    // Simultaneous I and D reads: D first, I four cycles later
    ack_lat = 2;
    fork
      i_read(32'h48, 1'b0, 1'b1);
      d_op(1'b0, 32'h08, 32'd0, 1'b0, 1'b1);
      begin
        @(negedge clk_i);
        @(negedge clk_i);
        check("t2_first_addr", mem_addr_o,        32'h08);
        check("t2_first_we",   {31'd0, mem_we_o}, 32'd0);
      end
    join
    check("t2_ready_gap", 32'(i_ready_cyc - d_ready_cyc), 32'd4);

    // D write, then read back through memory
    ack_lat = 1;
    fork
      d_op(1'b1, 32'h10, 32'h1234, 1'b0, 1'b1);
      begin
        @(negedge clk_i);
        @(negedge clk_i);
        check("t3_we",    {31'd0, mem_we_o}, 32'd1);
        check("t3_wdata", mem_wdata_o,       32'h1234);
        check("t3_addr",  mem_addr_o,        32'h10);
      end
    join
    d_op(1'b0, 32'h10, 32'd0, 1'b0, 1'b1);

    // Starvation: I held, D back-to-back; I must win the 5th arbitration
    done_order.delete();
    fork
      for (int k = 0; k < 6; k++) d_op(1'b0, 32'h60 + 32'(4 * k), 32'd0, 1'b0, k == 5);
      i_read(32'h4C, 1'b0, 1'b1);
    join
    nd = 0;
    seen_i = 1'b0;
    foreach (done_order[j]) begin
      if (!done_order[j]) seen_i = 1'b1;
      else if (!seen_i) nd++;
    end
    check("t4_d_before_i", 32'(nd), STARVE_MAX);
    check("t4_completions", 32'(done_order.size()), 32'd7);

    // Watchdog abort on a D read
    ack_lat = 0;
    hi = 0;
    fork
      d_op(1'b0, 32'h20, 32'd0, 1'b1, 1'b1);
      begin
        n = 0;
        while (!mem_req_o && n < 20) begin
          @(negedge clk_i);
          n++;
        end
        while (mem_req_o && hi < 50) begin
          hi++;
          @(negedge clk_i);
        end
      end
    join
    check("t5_busy_cycles", 32'(hi), TIMEOUT);
    check("t5_err",         {31'd0, err_o}, 32'd1);
    ack_lat = 1;
    i_read(32'h24, 1'b0, 1'b1);
    check("t5_err_sticky",  {31'd0, err_o}, 32'd1);

    // Ack with no transaction in flight is ignored
    spurious_ack = 1'b1;
    repeat (4) tick();
    spurious_ack = 1'b0;
    tick();
    check("t6_idata_hold",  idata_o,  i_last_exp);
    check("t6_drdata_hold", drdata_o, d_last_exp);
    check_stats("pre_rst");

    // Asynchronous reset in the middle of BUSY
    ack_lat = 0;
    ireq_i  = 1'b1;
    iaddr_i = 32'h44;
    repeat (3) @(negedge clk_i);
    check("t7_busy_before_rst", {31'd0, mem_req_o}, 32'd1);
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    iq.delete();
    dq.delete();
    n_igrant = 0;
    n_dgrant = 0;
    n_stall  = 0;
    i_last_exp = '0;
    d_last_exp = '0;
    #1;
    check("t7_rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("t7_rst_err",     {31'd0, err_o},     32'd0);
    check("t7_rst_idata",   idata_o,            32'd0);
    check("t7_rst_drdata",  drdata_o,           32'd0);
    check("t7_rst_addr",    mem_addr_o,         32'd0);
    check_stats("t7_rst");
    tick();
    ack_lat = 1;
    rst_i   = 1'b0;
    i_read(32'h44, 1'b0, 1'b1);
    check("t7_post_idata",  idata_o,            exp_mem[17]);
    check("t7_post_err",    {31'd0, err_o},     32'd0);
    tick();
    check_stats("final");
    check("iq_empty", 32'(iq.size()), 32'd0);
    check("dq_empty", 32'(dq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one multi-cycle unified memory port between the instruction-fetch requester (I) and the data-memory requester (D) of the 5-stage pipeline.
- Sits between Instruction_Memory/Data_Memory call sites and a single backing memory with a req/ack handshake.
- Produces per-requester ready pulses and stall levels that feed the PC and pipeline-register write enables.
- Fixed D-over-I priority with bounded I starvation, plus a watchdog on the memory handshake.

Parameters:
- STARVE_MAX, 4: consecutive lost arbitrations after which I wins the next arbitration (1..15).
- TIMEOUT, 64: BUSY cycles without mem_ack_i before the transaction is aborted (2..255).
- ERR_DATA, 32'hDEAD_BEEF: read data returned on an aborted transaction.

Ports:
- clk_i in 1: clock.
- rst_i in 1: asynchronous reset, active-high.
- ireq_i in 1: I read request (level).
- iaddr_i in 32: I address.
- idata_o out 32: I read data.
- iready_o out 1: I completion pulse.
- istall_o out 1: I waiting.
- drd_i in 1: D read request (level).
- dwr_i in 1: D write request (level).
- daddr_i in 32: D address.
- dwdata_i in 32: D write data.
- drdata_o out 32: D read data.
- dready_o out 1: D completion pulse.
- dstall_o out 1: D waiting.
- mem_req_o out 1: memory request.
- mem_we_o out 1: memory write enable.
- mem_addr_o out 32: memory address.
- mem_wdata_o out 32: memory write data.
- mem_ack_i in 1: memory completion.
- mem_rdata_i in 32: memory read data, valid with mem_ack_i.
- err_o out 1: sticky timeout flag.
- stat_igrant_o out 32: I grant count.
- stat_dgrant_o out 32: D grant count.
- stat_stall_o out 32: stall-cycle count.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0, including mem_req_o mid-transaction, err_o, data outputs and counters; starve_cnt=0; wd_cnt=0.
- States: IDLE -> BUSY -> DONE -> IDLE.
- Requester rules: req, address and write data are held stable from assertion until the cycle after its ready pulse. Requests are sampled only in IDLE.
- IDLE arbitration. dreq = drd_i | dwr_i.
  - ireq_i and starve_cnt==STARVE_MAX: grant I.
  - Else dreq: grant D.
  - Else ireq_i: grant I.
  - Else stay IDLE.
  - On grant, next edge loads mem_addr_o, mem_wdata_o (=dwdata_i for D) and mem_we_o (=dwr_i for D, 0 for I), sets mem_req_o=1, clears wd_cnt and moves to BUSY.
  - drd_i and dwr_i both high: treated as write.
- Starvation counter: increments (saturating at STARVE_MAX) on each D grant while ireq_i=1. Clears on an I grant, or in any cycle with ireq_i=0.
- BUSY: mem_req_o and the address/data/we outputs stay held.
  - mem_ack_i=1 at an edge: capture mem_rdata_i into idata_o or drdata_o (per grant; write grants leave drdata_o unchanged), drop mem_req_o and mem_we_o, go to DONE.
  - Else wd_cnt++. When wd_cnt reaches TIMEOUT-1 with no ack, abort instead: drop mem_req_o, load ERR_DATA into the granted read-data output (read only), set err_o, go to DONE.
  - A mem_ack_i arriving outside BUSY is ignored.
- DONE: exactly one cycle. The granted ready output is 1 (registered). No arbitration. Next state IDLE.
- Latency: request seen in IDLE at cycle 0; mem_req_o high from cycle 1; ack at cycle k gives ready during cycle k+1. The minimum with ack in cycle 1 is ready at cycle 2, and the next arbitration is at cycle 3.
- Stall levels: istall_o = ireq_i & ~iready_o; dstall_o = (drd_i|dwr_i) & ~dready_o (combinational).
- Data outputs hold their last value until overwritten.
- err_o clears only on rst_i.

Optional Feature:
- ARB_STATS_EN defined:
  - stat_igrant_o / stat_dgrant_o increment on each I / D grant.
  - stat_stall_o increments each cycle where istall_o|dstall_o.
  - All are 32-bit, wrap modulo 2^32, and are cleared by rst_i.
- ARB_STATS_EN undefined: the three stat ports stay present, are tied to 32'd0, and no counter flops are built.

Test Plan:
- I read alone: ireq_i=1, iaddr_i=0x40, mem acks with 0x8C020004 in 1st BUSY cycle -> mem_req_o high cycle 1, iready_o pulse cycle 2, idata_o=0x8C020004, istall_o=1 for cycles 0–1.
- Simultaneous: ireq_i and drd_i both high at cycle 0, each ack after 2 cycles -> D granted first (mem_addr_o=daddr_i, mem_we_o=0), I granted at next IDLE; dready_o precedes iready_o by 4 cycles.
- Write: dwr_i=1, daddr_i=0x10, dwdata_i=0x1234 -> mem_we_o=1, mem_wdata_o=0x1234 until ack, dready_o pulse, drdata_o unchanged.
- Starvation: STARVE_MAX=4, ireq_i held, D back-to-back requests -> after 4 D grants I wins the 5th arbitration even with dreq=1; starve_cnt then 0.
- Timeout: TIMEOUT=8, mem_ack_i held 0 on a D read -> mem_req_o drops after 8 BUSY cycles, drdata_o=0xDEADBEEF, dready_o pulse, err_o=1 held.
- Reset mid-BUSY: assert rst_i asynchronously -> mem_req_o, err_o and all outputs 0 immediately. After release with ireq_i=1, a fresh I transaction completes normally.
